galaksija_scandoubler: RTL and testbench

//  Line-doubling stage downstream of the Galaksija video generator. Captures each
//  15 kHz input line (pixel data, blank, syncs) into one half of a ping-pong line

---
 rtl/galaksija_scandoubler.sv | 218 +++++++++++++++++++++
 tb/tb_galaksija_scandoubler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/galaksija_scandoubler.sv
// Galaksija line doubler: captures each 15 kHz input line into a ping-pong buffer and
// replays it twice at the clk rate. Define SCANLINES_EN to halve the brightness of the second copy.
module galaksija_scandoubler #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 9,
    parameter int OUT_HS_LEN = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ce_pix,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_hsync,
    input  logic              in_vsync,
    input  logic              in_blank,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_hsync,
    output logic              out_vsync,
    output logic              out_blank,
    output logic [ADDR_W:0]   line_len
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int MEM_W = DATA_W + 1;
    localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(1 << ADDR_W);
    localparam logic [CNT_W-1:0] HS_LEN = CNT_W'(OUT_HS_LEN);

    typedef enum logic [1:0] {IDLE, LINE_A, LINE_B, WAIT} state_t;

    logic [MEM_W-1:0] mem [0:(2 << ADDR_W)-1];

    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              hs_prev_q, hs_prev_d;
    logic [CNT_W-1:0]  line_len_q, line_len_d;
    logic [CNT_W-1:0]  stored_cnt_q, stored_cnt_d;
    logic              rd_bank_q, rd_bank_d;
    logic              vs_pend_q, vs_pend_d;
    logic              start_q, start_d;
    logic              mem_we;
    logic [ADDR_W:0]   mem_waddr;

    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        pix_cnt_d    = pix_cnt_q;
        hs_prev_d    = hs_prev_q;
        line_len_d   = line_len_q;
        stored_cnt_d = stored_cnt_q;
        rd_bank_d    = rd_bank_q;
        vs_pend_d    = vs_pend_q;
        start_d      = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = {wr_bank_q, wr_addr_q};
        if (ce_pix) begin
            hs_prev_d = in_hsync;
            if (hs_prev_q && !in_hsync && (pix_cnt_q != '0)) begin
                line_len_d   = pix_cnt_q;
                stored_cnt_d = (pix_cnt_q > DEPTH) ? DEPTH : pix_cnt_q;
                rd_bank_d    = wr_bank_q;
                wr_bank_d    = ~wr_bank_q;
                vs_pend_d    = in_vsync;
                start_d      = 1'b1;
                // The sample carrying the hsync fall is pixel 0 of the new line.
                mem_we       = 1'b1;
                mem_waddr    = {~wr_bank_q, {ADDR_W{1'b0}}};
                wr_addr_d    = ADDR_W'(1);
                pix_cnt_d    = CNT_W'(1);
            end else begin
                mem_we = ~pix_cnt_q[ADDR_W];
                if (wr_addr_q != '1) wr_addr_d = wr_addr_q + ADDR_W'(1);
                if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= '0;
            pix_cnt_q    <= '0;
            hs_prev_q    <= 1'b1;
            line_len_q   <= '0;
            stored_cnt_q <= '0;
            rd_bank_q    <= 1'b1;
            vs_pend_q    <= 1'b1;
            start_q      <= 1'b0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            pix_cnt_q    <= pix_cnt_d;
            hs_prev_q    <= hs_prev_d;
            line_len_q   <= line_len_d;
            stored_cnt_q <= stored_cnt_d;
            rd_bank_q    <= rd_bank_d;
            vs_pend_q    <= vs_pend_d;
            start_q      <= start_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= {in_blank, in_dat};
    end

    // Playback latches bank/length at LINE_A entry so a new capture cannot disturb the tail.
    state_t           state_q;
    logic [CNT_W-1:0] out_x_q;
    logic             play_bank_q;
    logic [CNT_W-1:0] play_len_q;
    logic [CNT_W-1:0] play_stored_q;
    logic             vs_cur_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            out_x_q       <= '0;
            play_bank_q   <= 1'b0;
            play_len_q    <= '0;
            play_stored_q <= '0;
            vs_cur_q      <= 1'b1;
        end else if (start_q) begin
            state_q       <= LINE_A;
            out_x_q       <= '0;
            play_bank_q   <= rd_bank_q;
            play_len_q    <= line_len_q;
            play_stored_q <= stored_cnt_q;
            vs_cur_q      <= vs_pend_q;
        end else begin
            case (state_q)
                LINE_A: begin
                    if (out_x_q == play_len_q - CNT_W'(1)) begin
                        state_q <= LINE_B;
                        out_x_q <= '0;
                    end else begin
                        out_x_q <= out_x_q + CNT_W'(1);
                    end
                end
                LINE_B: begin
                    if (out_x_q == play_len_q - CNT_W'(1)) begin
                        state_q <= WAIT;
                        out_x_q <= '0;
                    end else begin
                        out_x_q <= out_x_q + CNT_W'(1);
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    logic [MEM_W-1:0] rd_word_q;

    always_ff @(posedge clk) begin
        rd_word_q <= mem[{play_bank_q, out_x_q[ADDR_W-1:0]}];
    end

    logic hs1_q, hs1_d, show1_q, show1_d, vs1_q, vs1_d;
`ifdef SCANLINES_EN
    logic half1_q, half1_d;
`endif
    logic              active;
    logic [DATA_W-1:0] pix;
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic              out_hsync_q, out_hsync_d, out_vsync_q, out_vsync_d;
    logic              out_blank_q, out_blank_d;

    always_comb begin
        active  = (state_q == LINE_A) || (state_q == LINE_B);
        hs1_d   = ~(active && (out_x_q < HS_LEN));
        show1_d = active && (out_x_q < play_stored_q);
        vs1_d   = vs_cur_q;
`ifdef SCANLINES_EN
        half1_d = (state_q == LINE_B);
`endif
        pix         = rd_word_q[DATA_W-1:0];
        out_blank_d = ~show1_q | rd_word_q[DATA_W];
`ifdef SCANLINES_EN
        if (half1_q) pix = {1'b0, pix[DATA_W-1:1]};
`endif
        out_dat_d   = out_blank_d ? '0 : pix;
        out_hsync_d = hs1_q;
        out_vsync_d = vs1_q;
    end

    // Stage 1 travels with the RAM read; stage 2 is the output register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs1_q       <= 1'b1;
            show1_q     <= 1'b0;
            vs1_q       <= 1'b1;
`ifdef SCANLINES_EN
            half1_q     <= 1'b0;
`endif
            out_dat_q   <= '0;
            out_hsync_q <= 1'b1;
            out_vsync_q <= 1'b1;
            out_blank_q <= 1'b1;
        end else begin
            hs1_q       <= hs1_d;
            show1_q     <= show1_d;
            vs1_q       <= vs1_d;
`ifdef SCANLINES_EN
            half1_q     <= half1_d;
`endif
            out_dat_q   <= out_dat_d;
            out_hsync_q <= out_hsync_d;
            out_vsync_q <= out_vsync_d;
            out_blank_q <= out_blank_d;
        end
    end

    assign out_dat   = out_dat_q;
    assign out_hsync = out_hsync_q;
    assign out_vsync = out_vsync_q;
    assign out_blank = out_blank_q;
    assign line_len  = line_len_q;

endmodule

// File: tb/tb_galaksija_scandoubler.sv
// Scoreboard bench for galaksija_scandoubler: captured lines are queued with their replay
// start cycle and a monitor compares every output clk against the replay rules.
module tb_galaksija_scandoubler;

    logic       clk = 1'b0;
    logic       resetn, ce_pix, in_hsync, in_vsync, in_blank;
    logic [7:0] in_dat;
    logic [7:0] out_dat;
    logic       out_hsync, out_vsync, out_blank;
    logic [9:0] line_len;

    always #5 clk = ~clk;

    galaksija_scandoubler #(.DATA_W(8), .ADDR_W(9), .OUT_HS_LEN(32)) dut (
        .clk(clk), .resetn(resetn), .ce_pix(ce_pix), .in_dat(in_dat),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_blank(in_blank),
        .out_dat(out_dat), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_blank(out_blank), .line_len(line_len)
    );

    typedef struct packed {
        logic [31:0] start;
        logic [31:0] idx;
        logic [31:0] len;
        logic        vs;
    } line_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    line_t       sb_q[$];
    logic [8:0]  ring [0:63][0:1023];
    int          wi = 0;
    int          col_cnt = 0;
    bit          prev_valid = 0;
    bit          prev_hs = 1;
    bit          len_pend = 0;
    int          exp_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            if (failures <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Reference capture: a line ends at an hsync fall between two samples; the falling sample opens the next line.
    task automatic model_sample(input logic [7:0] d, input bit hs, input bit vs, input bit blk);
        line_t e;
        if (prev_valid && prev_hs && !hs && col_cnt > 0) begin
            e.start = cyc + 4;
            e.idx   = wi;
            e.len   = col_cnt;
            e.vs    = vs;
            sb_q.push_back(e);
            exp_len  = col_cnt;
            len_pend = 1;
            wi       = (wi + 1) % 64;
            col_cnt  = 0;
        end
        if (col_cnt < 1024) ring[wi][col_cnt] = {blk, d};
        if (col_cnt < 1023) col_cnt++;
        prev_hs    = hs;
        prev_valid = 1;
    endtask

    task automatic tick(input bit ce, input logic [7:0] d, input bit hs, input bit vs, input bit blk);
        @(negedge clk);
        if (len_pend) begin
            check("line_len", 32'(line_len), exp_len);
            len_pend = 0;
        end
        ce_pix = ce; in_dat = d; in_hsync = hs; in_vsync = vs; in_blank = blk;
        if (ce && resetn) model_sample(d, hs, vs, blk);
    endtask

    task automatic pixel(input logic [7:0] d, input bit hs, input bit vs, input bit blk);
        tick(1'b1, d, hs, vs, blk);
        tick(1'b0, d, hs, vs, blk);
    endtask

    // mode 0: ramp data, 1: 0xFF with sparse blanking, 2: random data and blanking
    task automatic line(input int x0, input int x1, input int hs_len, input bit vs, input int mode);
        logic [7:0] d;
        bit         blk;
        for (int x = x0; x < x1; x++) begin
            case (mode)
                0:       begin d = 8'(x);  blk = (x < 40); end
                1:       begin d = 8'hFF;  blk = (x < 40) || (x % 7 == 0); end
                default: begin d = 8'($urandom); blk = ($urandom_range(5, 0) == 0); end
            endcase
            pixel(d, x >= hs_len, vs, blk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_out_dat", 32'(out_dat), 0);
        check("rst_out_hsync", 32'(out_hsync), 1);
        check("rst_out_vsync", 32'(out_vsync), 1);
        check("rst_out_blank", 32'(out_blank), 1);
        check("rst_line_len", 32'(line_len), 0);
        prev_valid = 0;
        col_cnt    = 0;
        len_pend   = 0;
        repeat (3) pixel(8'h00, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: replays queued lines twice, one pixel per clk, from each line's start cycle.
    initial begin : monitor
        line_t      cur;
        int         pos, x, cp, stored;
        bit         active, lvs, e_hs, e_blk;
        logic [7:0] e_dat;
        logic [8:0] w;
        cur = '0; pos = 0; active = 0; lvs = 1;
        forever begin
            @(posedge clk);
            #2;
            if (!resetn) begin
                sb_q.delete();
                active = 0;
                lvs    = 1;
                continue;
            end
            if (sb_q.size() > 0 && sb_q[0].start == 32'(cyc)) begin
                cur    = sb_q.pop_front();
                active = 1;
                pos    = 0;
                lvs    = cur.vs;
            end
            e_dat = 8'h00; e_hs = 1; e_blk = 1;
            if (active) begin
                x      = pos % int'(cur.len);
                cp     = pos / int'(cur.len);
                stored = (cur.len < 512) ? int'(cur.len) : 512;
                e_hs   = !(x < 32);
                w      = ring[cur.idx][x];
                if (x < stored && !w[8]) begin
                    e_blk = 0;
                    e_dat = w[7:0];
`ifdef SCANLINES_EN
                    if (cp == 1) e_dat = e_dat >> 1;
`endif
                end
                pos++;
                if (pos >= 2 * int'(cur.len)) active = 0;
            end
            check($sformatf("out{dat,hs,vs,blank}@cyc%0d", cyc),
                  32'({out_dat, out_hsync, out_vsync, out_blank}),
                  32'({e_dat, e_hs, lvs, e_blk}));
        end
    end

    initial begin : stimulus
        int len, hsl;
        bit vs;
        resetn = 1'b0; ce_pix = 1'b0; in_dat = 8'h00;
        in_hsync = 1'b1; in_vsync = 1'b1; in_blank = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        // ramp lines of 408 pixels
        repeat (3) line(0, 408, 30, 1'b1, 0);
        // bright line with blanked pixels
        line(0, 408, 30, 1'b1, 1);
        // long line: pixels beyond the buffer come out blanked
        line(0, 600, 30, 1'b1, 0);
        // short line truncates the second copy of the previous line
        line(0, 408, 30, 1'b1, 0);
        line(0, 304, 30, 1'b1, 0);
        // vsync low for three input lines
        line(0, 408, 30, 1'b1, 0);
        repeat (3) line(0, 408, 30, 1'b0, 0);
        repeat (2) line(0, 408, 30, 1'b1, 2);
        // random lengths, syncs and content
        for (int i = 0; i < 12; i++) begin
            len = $urandom_range(620, 320);
            hsl = $urandom_range(40, 8);
            vs  = ($urandom_range(3, 0) != 0);
            line(0, len, hsl, vs, 2);
        end
        // reset while a vsync-low output line is in its hsync pulse
        line(0, 10, 30, 1'b0, 0);
        do_reset();
        line(10, 408, 30, 1'b0, 0);
        repeat (2) line(0, 408, 30, 1'b1, 0);
        line(0, 408, 30, 1'b1, 2);
        line(0, 900, 900, 1'b1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
